ahb_region_decoder: RTL and testbench

Registered, multi-region AHB-Lite address decoder and response multiplexer for the uncore bus. It decodes each address-phase transfer against `NREGIONS` configurable base/range windows using per-region size and access-type checks, and drives one-hot slave selects. It tracks the data phase to mux slave responses back to the master. Unmapped or illegal transfers go to an internal default slave, which returns a two-cycle AHB ERROR and logs the fault in a sticky error register with a saturating counter.

---
 rtl/ahb_region_decoder.sv | 174 +++++++++++++++++
 tb/tb_ahb_region_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_region_decoder.sv
// AHB-Lite multi-region address decoder and response multiplexer.
// Decodes each address-phase transfer against NREGIONS base/mask windows and
// drives a one-hot HSEL. It registers the data-phase owner and muxes the slave
// responses back to the master. Unmapped or illegal transfers go to an internal
// default slave, which returns a two-cycle ERROR and logs the fault.

// Per-window match and permission check (one instance per region)
module ahb_region_match #(
  parameter int PA_BITS = 34
) (
  input  logic [PA_BITS-1:0] haddr,
  input  logic [PA_BITS-1:0] base,
  input  logic [PA_BITS-1:0] rng,
  input  logic               supported,
  input  logic               readable,
  input  logic               writable,
  input  logic [3:0]         sizemask,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  output logic               hit,
  output logic               ok
);
  // Bits covered by the range mask are don't-care; all others must equal base.
  assign hit = (&((haddr ~^ base) | rng)) & supported;
  // Sizes above 8 bytes are never legal; otherwise the mask bit selects the size.
  assign ok  = ~hsize[2] & sizemask[hsize[1:0]] & (hwrite ? writable : readable);
endmodule

module ahb_region_decoder #(
  parameter int PA_BITS     = 34,
  parameter int NREGIONS    = 8,
  parameter int XLEN        = 64,
  parameter int ERRCNT_BITS = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [PA_BITS-1:0]           HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [NREGIONS*PA_BITS-1:0]  RegionBase,
  input  logic [NREGIONS*PA_BITS-1:0]  RegionRange,
  input  logic [NREGIONS-1:0]          RegionSupported,
  input  logic [NREGIONS-1:0]          RegionReadable,
  input  logic [NREGIONS-1:0]          RegionWritable,
  input  logic [NREGIONS*4-1:0]        RegionSizeMask,
  input  logic [NREGIONS-1:0]          HREADYOUT_S,
  input  logic [NREGIONS-1:0]          HRESP_S,
  input  logic [NREGIONS*XLEN-1:0]     HRDATA_S,
  output logic [NREGIONS-1:0]          HSEL,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [XLEN-1:0]              HRDATA,
  input  logic                         ErrClear,
  output logic                         ErrValid,
  output logic [PA_BITS-1:0]           ErrAddr,
  output logic                         ErrWrite,
  output logic [ERRCNT_BITS-1:0]       ErrCount
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR1 = 2'd1;
  localparam logic [1:0] S_ERR2 = 2'd2;

  logic                act, dec_err, err_acc;
  logic [NREGIONS-1:0] hit, ok, win;
  logic [NREGIONS-1:0] sel_d;
  logic                sel_def;
  logic [1:0]          state, state_nxt;
  logic                unused_htrans0;

  assign act            = HTRANS[1];
  assign unused_htrans0 = HTRANS[0];

  for (genvar g = 0; g < NREGIONS; g++) begin : g_rgn
    ahb_region_match #(.PA_BITS(PA_BITS)) u_match (
      .haddr     (HADDR),
      .base      (RegionBase[g*PA_BITS +: PA_BITS]),
      .rng       (RegionRange[g*PA_BITS +: PA_BITS]),
      .supported (RegionSupported[g]),
      .readable  (RegionReadable[g]),
      .writable  (RegionWritable[g]),
      .sizemask  (RegionSizeMask[g*4 +: 4]),
      .hwrite    (HWRITE),
      .hsize     (HSIZE),
      .hit       (hit[g]),
      .ok        (ok[g])
    );
  end

  // Lowest-index hit owns the address even if its permission check fails
  always_comb begin : prio
    logic found;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      win[i] = hit[i] & ~found;
      found  = found | hit[i];
    end
  end

  assign HSEL    = act ? (win & ok) : '0;
  assign dec_err = act & ~|(win & ok);
  assign err_acc = dec_err & HREADY;

  // Data-phase response mux: region slave, default slave, or nothing
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (sel_def) begin
      HREADY = (state != S_ERR1);
      HRESP  = (state != S_IDLE);
    end else begin
      for (int i = 0; i < NREGIONS; i++) begin
        if (sel_d[i]) begin
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
          HRDATA = HRDATA_S[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Data-phase owner advances only when the current transfer completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_d   <= '0;
      sel_def <= 1'b0;
    end else if (HREADY) begin
      sel_d   <= HSEL;
      sel_def <= dec_err;
    end
  end

  // Default-slave next state: two-cycle ERROR, chained for back-to-back errors
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = err_acc ? S_ERR1 : S_IDLE;
      S_ERR1:  state_nxt = S_ERR2;
      S_ERR2:  state_nxt = err_acc ? S_ERR1 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Default-slave state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Error log: first fault is sticky, count saturates; a new error beats clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ErrValid <= 1'b0;
      ErrAddr  <= '0;
      ErrWrite <= 1'b0;
      ErrCount <= '0;
    end else if (err_acc) begin
      ErrCount <= ErrClear ? ERRCNT_BITS'(1) :
                  (&ErrCount) ? ErrCount : ErrCount + 1'b1;
      if (!ErrValid || ErrClear) begin
        ErrValid <= 1'b1;
        ErrAddr  <= HADDR;
        ErrWrite <= HWRITE;
      end
    end else if (ErrClear) begin
      ErrValid <= 1'b0;
      ErrAddr  <= '0;
      ErrWrite <= 1'b0;
      ErrCount <= '0;
    end
  end
endmodule

// File: tb/tb_ahb_region_decoder.sv
// Directed bench for ahb_region_decoder with three overlapping windows.
// Stimulus queues hand-computed expectations tagged with the cycle they apply
// to; a negedge monitor pops and compares them against the DUT.
module tb_ahb_region_decoder;
  localparam int PA = 34, NR = 3, XL = 64, EB = 8;

  localparam int S_HSEL = 0, S_RDY = 1, S_RESP = 2, S_RDATA = 3,
                 S_EVAL = 4, S_EADDR = 5, S_EWR = 6, S_ECNT = 7;

  localparam logic [63:0] D0 = 64'hD000_0000_0000_00A0;
  localparam logic [63:0] D1 = 64'hD000_0000_0000_00A1;
  localparam logic [63:0] D2 = 64'hD000_0000_0000_00A2;

  logic            HCLK = 1'b0, HRESETn = 1'b0;
  logic [PA-1:0]   HADDR = '0;
  logic [1:0]      HTRANS = 2'b00;
  logic            HWRITE = 1'b0;
  logic [2:0]      HSIZE = 3'd0;
  logic [NR*PA-1:0] RegionBase, RegionRange;
  logic [NR-1:0]   RegionSupported = 3'b111;
  logic [NR-1:0]   RegionReadable  = 3'b111;
  logic [NR-1:0]   RegionWritable  = 3'b101;
  logic [NR*4-1:0] RegionSizeMask  = {4'b1111, 4'b0100, 4'b1111};
  logic [NR-1:0]   HREADYOUT_S = 3'b111;
  logic [NR-1:0]   HRESP_S = 3'b000;
  logic [NR*XL-1:0] HRDATA_S;
  logic [NR-1:0]   HSEL;
  logic            HREADY, HRESP;
  logic [XL-1:0]   HRDATA;
  logic            ErrClear = 1'b0;
  logic            ErrValid, ErrWrite;
  logic [PA-1:0]   ErrAddr;
  logic [EB-1:0]   ErrCount;

  assign RegionBase  = {34'h0, 34'h1000_0000, 34'h1000};
  assign RegionRange = {34'h3_FFFF_FFFF, 34'hFF, 34'hFFF};
  assign HRDATA_S    = {D2, D1, D0};

  ahb_region_decoder #(.PA_BITS(PA), .NREGIONS(NR), .XLEN(XL), .ERRCNT_BITS(EB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .RegionBase(RegionBase),
    .RegionRange(RegionRange), .RegionSupported(RegionSupported),
    .RegionReadable(RegionReadable), .RegionWritable(RegionWritable),
    .RegionSizeMask(RegionSizeMask), .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S), .HSEL(HSEL), .HREADY(HREADY),
    .HRESP(HRESP), .HRDATA(HRDATA), .ErrClear(ErrClear), .ErrValid(ErrValid),
    .ErrAddr(ErrAddr), .ErrWrite(ErrWrite), .ErrCount(ErrCount)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int s);
    case (s)
      S_HSEL:  return 64'(HSEL);
      S_RDY:   return 64'(HREADY);
      S_RESP:  return 64'(HRESP);
      S_RDATA: return HRDATA;
      S_EVAL:  return 64'(ErrValid);
      S_EADDR: return 64'(ErrAddr);
      S_EWR:   return 64'(ErrWrite);
      default: return 64'(ErrCount);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; stale ones count as misses
  always @(negedge HCLK) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if (q[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", q[i].nm, q[i].cyc, cyc);
        end else if (actual(q[i].sig) !== q[i].val) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", q[i].nm, actual(q[i].sig), q[i].val, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic chk(input int s, input logic [63:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.val = v; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic xfer(input logic [PA-1:0] a, input logic w, input logic [2:0] s);
    HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = s;
  endtask

  task automatic idle();
    HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0;
  endtask

  task automatic resp(input logic r, input logic p, input string nm);
    chk(S_RDY, 64'(r), {nm, "_hready"});
    chk(S_RESP, 64'(p), {nm, "_hresp"});
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();
    chk(S_HSEL, 0, "rst_hsel"); resp(1, 0, "rst"); chk(S_RDATA, 0, "rst_hrdata");
    chk(S_EVAL, 0, "rst_errvalid"); chk(S_EADDR, 0, "rst_erraddr");
    chk(S_EWR, 0, "rst_errwrite"); chk(S_ECNT, 0, "rst_errcount");

    // region 0 read with 2 wait states
    tick(); xfer(34'h1004, 1'b0, 3'd3);
    chk(S_HSEL, 3'b001, "r0_hsel"); chk(S_RDY, 1, "r0_addr_hready");
    tick(); idle(); HREADYOUT_S = 3'b110;
    chk(S_RDY, 0, "r0_wait1"); chk(S_RDATA, D0, "r0_rdata_w1");
    tick();
    chk(S_RDY, 0, "r0_wait2");
    tick(); HREADYOUT_S = 3'b111;
    chk(S_RDY, 1, "r0_done"); chk(S_RDATA, D0, "r0_rdata");
    tick();
    chk(S_RDATA, 0, "r0_after_rdata"); resp(1, 0, "r0_after");

    // write to read-only region 1 must not fall through to region 2
    tick(); xfer(34'h1000_0010, 1'b1, 3'd2);
    chk(S_HSEL, 3'b000, "ro_hsel");
    tick(); idle();
    resp(0, 1, "ro_err1");
    chk(S_EVAL, 1, "ro_errvalid"); chk(S_EADDR, 34'h1000_0010, "ro_erraddr");
    chk(S_EWR, 1, "ro_errwrite"); chk(S_ECNT, 1, "ro_errcount");
    tick(); resp(1, 1, "ro_err2");
    tick(); resp(1, 0, "ro_idle");

    // clear log, then back-to-back size errors
    tick(); ErrClear = 1'b1;
    tick(); ErrClear = 1'b0;
    chk(S_EVAL, 0, "clr_errvalid"); chk(S_ECNT, 0, "clr_errcount"); chk(S_EADDR, 0, "clr_erraddr");
    tick(); xfer(34'h1000_0000, 1'b0, 3'd1);
    chk(S_HSEL, 0, "b2b_hsel");
    tick(); xfer(34'h1000_0004, 1'b0, 3'd0);
    resp(0, 1, "b2b_err1a"); chk(S_ECNT, 1, "b2b_cnt1");
    chk(S_EADDR, 34'h1000_0000, "b2b_addr1"); chk(S_EWR, 0, "b2b_write1");
    tick(); resp(1, 1, "b2b_err2a"); chk(S_ECNT, 1, "b2b_cnt_hold");
    tick(); idle();
    resp(0, 1, "b2b_err1b"); chk(S_ECNT, 2, "b2b_cnt2");
    chk(S_EADDR, 34'h1000_0000, "b2b_addr_sticky");
    tick(); resp(1, 1, "b2b_err2b");
    tick(); resp(1, 0, "b2b_idle");

    // saturate the counter with a continuous stream of errors
    tick(); xfer(34'h1000_0000, 1'b0, 3'd1);
    repeat (600) tick();
    idle();
    repeat (3) tick();
    chk(S_ECNT, 8'hFF, "sat_count"); chk(S_EADDR, 34'h1000_0000, "sat_addr"); resp(1, 0, "sat_idle");

    // clear coinciding with an accepted error: error wins
    tick(); xfer(34'h1000_0008, 1'b0, 3'd3); ErrClear = 1'b1;
    tick(); idle(); ErrClear = 1'b0;
    chk(S_ECNT, 1, "clrerr_count"); chk(S_EADDR, 34'h1000_0008, "clrerr_addr");
    chk(S_EVAL, 1, "clrerr_valid"); resp(0, 1, "clrerr_err1");
    tick(); resp(1, 1, "clrerr_err2");
    tick();

    // catch-all region 2, then disable it
    tick(); xfer(34'h2_0000_0000, 1'b0, 3'd3);
    chk(S_HSEL, 3'b100, "r2_hsel");
    tick(); idle();
    chk(S_RDATA, D2, "r2_rdata"); resp(1, 0, "r2_data");
    tick(); RegionSupported = 3'b011; xfer(34'h2_0000_0000, 1'b0, 3'd3);
    chk(S_HSEL, 0, "r2off_hsel");
    tick(); idle();
    resp(0, 1, "r2off_err1"); chk(S_ECNT, 2, "r2off_count");
    chk(S_EADDR, 34'h1000_0008, "r2off_addr_sticky");
    tick(); resp(1, 1, "r2off_err2");
    tick(); resp(1, 0, "r2off_idle");

    // async reset during ERR1
    tick(); xfer(34'h2_0000_0000, 1'b0, 3'd3);
    tick(); idle();
    #1 HRESETn = 1'b0;
    resp(1, 0, "rstmid"); chk(S_ECNT, 0, "rstmid_count");
    chk(S_EVAL, 0, "rstmid_valid"); chk(S_RDATA, 0, "rstmid_rdata");
    tick(); HRESETn = 1'b1; RegionSupported = 3'b111;
    resp(1, 0, "rstrel");
    tick();
    chk(S_HSEL, 0, "final_hsel");

    // drain the scoreboard with a bounded wait
    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge HCLK);
    #1;
    while (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL %s: expectation left unchecked, got none expected %0h", q[0].nm, q[0].val);
      void'(q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
